// File: rtl/hbm_pkg.sv
// Shared definitions for the Hamming best-match engine.
//   hbm_state_t : sweep FSM state encoding
//   POP_CHUNK   : popcount slice width in bits
//   RATIO_NUM   : ratio-test numerator (used only when HBM_RATIO_TEST_EN is defined)
//   RATIO_DEN   : ratio-test denominator (used only when HBM_RATIO_TEST_EN is defined)
//   popcount64  : number of set bits in one 64-bit slice
package hbm_pkg;

  localparam int POP_CHUNK = 64;
  localparam int RATIO_NUM = 3;
  localparam int RATIO_DEN = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hbm_state_t;

  function automatic logic [6:0] popcount64(input logic [63:0] w);
    logic [6:0] cnt;
    cnt = '0;
    for (int i = 0; i < 64; i++) begin
      cnt = cnt + 7'(w[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/hbm_popcount.sv
// Two-cycle registered popcount of a DWIDTH-bit word.
// Cycle 1 registers one popcount per 64-bit slice; cycle 2 registers their sum.
//   clk   in  clock
//   rstb  in  synchronous active-high reset
//   data  in  DWIDTH  word to count
//   sum   out DW      registered popcount of data, two cycles later
module hbm_popcount
  import hbm_pkg::*;
#(
  parameter int DWIDTH = 256,
  parameter int DW     = $clog2(DWIDTH + 1)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic [DWIDTH-1:0] data,
  output logic [DW-1:0]     sum
);

  localparam int NCHUNK = DWIDTH / POP_CHUNK;

  logic [6:0]    chunk_q [NCHUNK];
  logic [DW-1:0] sum_c;

  always_ff @(posedge clk) begin
    if (rstb) begin
      for (int i = 0; i < NCHUNK; i++) begin
        chunk_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCHUNK; i++) begin
        chunk_q[i] <= popcount64(data[i*POP_CHUNK +: POP_CHUNK]);
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      sum_c = sum_c + DW'(chunk_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rstb) sum <= '0;
    else      sum <= sum_c;
  end

endmodule

// File: rtl/hamming_best_match.sv
// Sweeps up to DEPTH descriptors from an attached URAM and reports the index
// and Hamming distance of the closest one to a query, plus the runner-up
// distance. Read data is counted on ram_valid, so any URAM read latency works.
// Build option: define HBM_RATIO_TEST_EN to make match_ok a 4*best < 3*second
// ratio test; otherwise match_ok just flags a non-empty sweep.
//   clk, rstb           clock, synchronous active-high reset
//   start, query        sweep request and query descriptor
//   num_desc            descriptors to compare (clamped to DEPTH)
//   ram_en, ram_regce   URAM read enables
//   ram_addr            URAM read address
//   ram_valid, ram_dout URAM read return
//   busy                sweep in progress
//   match_valid         one-cycle result strobe
//   best_idx, best_dist, second_dist, match_ok  results
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | one URAM read per cycle, addresses 0..n-1
// DRAIN | waiting for the last returns to leave the compare pipeline
// DONE  | strobe match_valid, results held
module hamming_best_match
  import hbm_pkg::*;
#(
  parameter int DEPTH  = 1000,
  parameter int DWIDTH = 256,
  parameter int AW     = $clog2(DEPTH),
  parameter int DW     = $clog2(DWIDTH + 1)
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              start,
  input  logic [DWIDTH-1:0] query,
  input  logic [AW:0]       num_desc,
  output logic              ram_en,
  output logic              ram_regce,
  output logic [AW-1:0]     ram_addr,
  input  logic              ram_valid,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic              busy,
  output logic              match_valid,
  output logic [AW-1:0]     best_idx,
  output logic [DW-1:0]     best_dist,
  output logic [DW-1:0]     second_dist,
  output logic              match_ok
);

  hbm_state_t state, next_state;

  logic [DWIDTH-1:0] q_reg;
  logic [AW:0]       n_reg;
  logic [AW-1:0]     issue_cnt;
  logic [AW:0]       ret_cnt;

  logic [DWIDTH-1:0] s1_xor;
  logic              s1_v, s2_v, s3_v;
  logic [AW-1:0]     s1_idx, s2_idx, s3_idx;
  logic [DW-1:0]     pc_sum;

  logic accept, pipe_empty, issue_last, start_ok, ratio_ok;

  assign start_ok   = (state == IDLE) && start;
  assign accept     = ram_valid && ((state == ISSUE) || (state == DRAIN)) && (ret_cnt < n_reg);
  assign pipe_empty = !s1_v && !s2_v && !s3_v;
  assign issue_last = ({1'b0, issue_cnt} == (n_reg - 1'b1));

`ifdef HBM_RATIO_TEST_EN
  logic [DW+1:0] ratio_lhs, ratio_rhs;
  assign ratio_lhs = (DW+2)'(RATIO_DEN) * (DW+2)'(best_dist);
  assign ratio_rhs = (DW+2)'(RATIO_NUM) * (DW+2)'(second_dist);
  assign ratio_ok  = (ratio_lhs < ratio_rhs);
`else
  assign ratio_ok  = (n_reg != '0);
`endif

  always_ff @(posedge clk) begin
    if (rstb) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (start) next_state = ISSUE;
      ISSUE: begin
        if (n_reg == '0)     next_state = DONE;
        else if (issue_last) next_state = DRAIN;
      end
      DRAIN: if ((ret_cnt == n_reg) && pipe_empty) next_state = DONE;
      DONE:  next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    ram_en      = 1'b0;
    busy        = 1'b0;
    match_valid = 1'b0;
    case (state)
      ISSUE: begin
        ram_en = (n_reg != '0);
        busy   = 1'b1;
      end
      DRAIN:   busy = 1'b1;
      DONE:    match_valid = 1'b1;
      default: ;
    endcase
  end

  assign ram_regce = ram_en;
  // issue_cnt parks on the last address, so ram_addr holds outside ISSUE.
  assign ram_addr  = issue_cnt;

  always_ff @(posedge clk) begin
    if (rstb) begin
      q_reg       <= '0;
      n_reg       <= '0;
      issue_cnt   <= '0;
      ret_cnt     <= '0;
      s1_xor      <= '0;
      s1_v        <= 1'b0;
      s2_v        <= 1'b0;
      s3_v        <= 1'b0;
      s1_idx      <= '0;
      s2_idx      <= '0;
      s3_idx      <= '0;
      best_idx    <= '0;
      best_dist   <= '0;
      second_dist <= '0;
      match_ok    <= 1'b0;
    end else begin
      s1_v   <= accept;
      s1_xor <= q_reg ^ ram_dout;
      s1_idx <= ret_cnt[AW-1:0];
      s2_v   <= s1_v;
      s2_idx <= s1_idx;
      s3_v   <= s2_v;
      s3_idx <= s2_idx;

      if (accept) ret_cnt <= ret_cnt + 1'b1;

      if ((state == ISSUE) && (n_reg != '0) && !issue_last)
        issue_cnt <= issue_cnt + 1'b1;

      // Strict less-than keeps the earlier (lower) index on ties, since
      // returns arrive in address order.
      if (s3_v) begin
        if (pc_sum < best_dist) begin
          second_dist <= best_dist;
          best_dist   <= pc_sum;
          best_idx    <= s3_idx;
        end else if (pc_sum < second_dist) begin
          second_dist <= pc_sum;
        end
      end

      // The pipeline is empty here, so best/second are final.
      if ((state != DONE) && (next_state == DONE))
        match_ok <= ratio_ok;

      if (start_ok) begin
        q_reg       <= query;
        n_reg       <= (num_desc > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_desc;
        issue_cnt   <= '0;
        ret_cnt     <= '0;
        best_idx    <= '0;
        best_dist   <= DW'(DWIDTH);
        second_dist <= DW'(DWIDTH);
        match_ok    <= 1'b0;
      end
    end
  end

  hbm_popcount #(
    .DWIDTH (DWIDTH),
    .DW     (DW)
  ) u_popcount (
    .clk  (clk),
    .rstb (rstb),
    .data (s1_xor),
    .sum  (pc_sum)
  );

endmodule

// File: tb/tb_hamming_best_match.sv
module tb_hamming_best_match;

  localparam int DEPTH  = 8;
  localparam int DWIDTH = 256;
  localparam int AW     = 4;
  localparam int DW     = 9;
  localparam int LAT    = 6;
`ifdef HBM_RATIO_TEST_EN
  localparam bit RATIO = 1'b1;
`else
  localparam bit RATIO = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rstb = 1'b1;
  logic              start = 1'b0;
  logic [DWIDTH-1:0] query = '0;
  logic [AW:0]       num_desc = '0;
  logic              ram_en, ram_regce;
  logic [AW-1:0]     ram_addr;
  logic              ram_valid;
  logic [DWIDTH-1:0] ram_dout;
  logic              busy, match_valid, match_ok;
  logic [AW-1:0]     best_idx;
  logic [DW-1:0]     best_dist, second_dist;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hamming_best_match #(
    .DEPTH(DEPTH), .DWIDTH(DWIDTH), .AW(AW), .DW(DW)
  ) dut (
    .clk(clk), .rstb(rstb), .start(start), .query(query), .num_desc(num_desc),
    .ram_en(ram_en), .ram_regce(ram_regce), .ram_addr(ram_addr),
    .ram_valid(ram_valid), .ram_dout(ram_dout), .busy(busy),
    .match_valid(match_valid), .best_idx(best_idx), .best_dist(best_dist),
    .second_dist(second_dist), .match_ok(match_ok)
  );

  // URAM model: fixed LAT-cycle read latency.
  logic [DWIDTH-1:0] mem [DEPTH];
  logic [LAT-1:0]    vpipe = '0;
  logic [DWIDTH-1:0] dpipe [LAT];
  logic              stray = 1'b0;
  logic [DWIDTH-1:0] stray_dout = '0;

  always @(posedge clk) begin
    vpipe    <= {vpipe[LAT-2:0], ram_en};
    dpipe[0] <= mem[ram_addr[2:0]];
    for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
  end

  assign ram_valid = vpipe[LAT-1] | stray;
  assign ram_dout  = stray ? stray_dout : dpipe[LAT-1];

  int          en_cnt = 0;
  logic [AW-1:0] addr_log [$];
  always @(negedge clk) begin
    if (ram_en) begin
      en_cnt <= en_cnt + 1;
      addr_log.push_back(ram_addr);
    end
  end

  logic [DWIDTH-1:0] q0;
  int dist_k [DEPTH] = '{9, 4, 7, 4, 200, 1, 3, 2};
  int dist_o [DEPTH] = '{0, 252, 100, 60, 30, 255, 126, 190};

  task automatic load_mem();
    logic [DWIDTH-1:0] m;
    q0 = {8{32'hDEADBEEF}};
    for (int w = 0; w < DEPTH; w++) begin
      m = '0;
      for (int j = 0; j < dist_k[w]; j++) m[dist_o[w] + j] = 1'b1;
      mem[w] = q0 ^ m;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstb = 1'b1;
    repeat (2) @(negedge clk);
    rstb = 1'b0;
  endtask

  // Pulses start at a negedge and waits for match_valid; lat counts clock
  // edges from the start edge to the cycle where match_valid is seen.
  task automatic run_sweep(input logic [DWIDTH-1:0] qv, input logic [AW:0] nd,
                           output int lat, output bit timed_out);
    @(negedge clk);
    query = qv; num_desc = nd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!match_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    timed_out = !match_valid;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({busy, match_valid, ram_en, ram_regce} !== 4'b0) begin
      errors++; $display("FAIL reset_ctrl got=%b want=0000", {busy, match_valid, ram_en, ram_regce});
    end
    checks++;
    if ({ram_addr, best_idx, best_dist, second_dist, match_ok} !== '0) begin
      errors++; $display("FAIL reset_data addr=%0d idx=%0d best=%0d second=%0d ok=%0b want all 0",
                         ram_addr, best_idx, best_dist, second_dist, match_ok);
    end
  endtask

  task automatic test_full_sweep();
    int lat; bit to; int e0; int a0;
    e0 = en_cnt; a0 = addr_log.size();
    run_sweep(q0, 5'd8, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL full_timeout got=no match_valid want=match_valid"); end
    checks++;
    if (en_cnt - e0 !== 8) begin errors++; $display("FAIL full_en_cnt got=%0d want=8", en_cnt - e0); end
    checks++;
    if (best_idx !== 4'd5) begin errors++; $display("FAIL full_idx got=%0d want=5", best_idx); end
    checks++;
    if (best_dist !== 9'd1) begin errors++; $display("FAIL full_best got=%0d want=1", best_dist); end
    checks++;
    if (second_dist !== 9'd2) begin errors++; $display("FAIL full_second got=%0d want=2", second_dist); end
    checks++;
    if (match_ok !== 1'b1) begin errors++; $display("FAIL full_ok got=%0b want=1", match_ok); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_done got=%0b want=0", busy); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (addr_log[a0 + i] !== AW'(i)) begin
        errors++; $display("FAIL full_addr%0d got=%0d want=%0d", i, addr_log[a0 + i], i);
      end
    end
    @(negedge clk);
    checks++;
    if (match_valid !== 1'b0) begin errors++; $display("FAIL strobe_width got=%0b want=0", match_valid); end
    checks++;
    if ({best_idx, best_dist, second_dist} !== {4'd5, 9'd1, 9'd2}) begin
      errors++; $display("FAIL result_hold got=%0d/%0d/%0d want=5/1/2", best_idx, best_dist, second_dist);
    end
  endtask

  task automatic test_partial_tie();
    int lat; bit to;
    run_sweep(q0, 5'd4, lat, to);
    checks++;
    if (to) begin errors++; $display("FAIL tie_timeout got=no match_valid want=match_valid"); end
    checks++;
    if (best_idx !== 4'd1) begin errors++; $display("FAIL tie_idx got=%0d want=1", best_idx); end
    checks++;
    if (best_dist !== 9'd4) begin errors++; $display("FAIL tie_best got=%0d want=4", best_dist); end
    checks++;
    if (second_dist !== 9'd4) begin errors++; $display("FAIL tie_second got=%0d want=4", second_dist); end
    checks++;
    if (match_ok !== !RATIO) begin errors++; $display("FAIL tie_ok got=%0b want=%0b", match_ok, !RATIO); end
  endtask

  task automatic test_zero();
    int lat; bit to; int e0;
    e0 = en_cnt;
    run_sweep(q0, 5'd0, lat, to);
    checks++;
    if (to || lat !== 2) begin errors++; $display("FAIL zero_latency got=%0d want=2", lat); end
    checks++;
    if (en_cnt - e0 !== 0) begin errors++; $display("FAIL zero_en_cnt got=%0d want=0", en_cnt - e0); end
    checks++;
    if ({best_idx, best_dist, second_dist, match_ok} !== {4'd0, 9'd256, 9'd256, 1'b0}) begin
      errors++; $display("FAIL zero_result got=%0d/%0d/%0d/%0b want=0/256/256/0",
                         best_idx, best_dist, second_dist, match_ok);
    end
  endtask

  task automatic test_one();
    int lat; bit to;
    run_sweep(q0, 5'd1, lat, to);
    checks++;
    if (to || {best_idx, best_dist, second_dist, match_ok} !== {4'd0, 9'd9, 9'd256, 1'b1}) begin
      errors++; $display("FAIL one_result got=%0d/%0d/%0d/%0b want=0/9/256/1",
                         best_idx, best_dist, second_dist, match_ok);
    end
  endtask

  task automatic test_clamp();
    int lat; bit to; int e0; int a0;
    e0 = en_cnt; a0 = addr_log.size();
    run_sweep(q0, 5'd20, lat, to);
    checks++;
    if (en_cnt - e0 !== 8) begin errors++; $display("FAIL clamp_en_cnt got=%0d want=8", en_cnt - e0); end
    checks++;
    if (addr_log[a0] !== 4'd0 || addr_log[a0 + 7] !== 4'd7) begin
      errors++; $display("FAIL clamp_addr got=%0d..%0d want=0..7", addr_log[a0], addr_log[a0 + 7]);
    end
    checks++;
    if (to || {best_idx, best_dist, second_dist} !== {4'd5, 9'd1, 9'd2}) begin
      errors++; $display("FAIL clamp_result got=%0d/%0d/%0d want=5/1/2", best_idx, best_dist, second_dist);
    end
  endtask

  task automatic test_reset_mid();
    int lat; bit to;
    @(negedge clk);
    query = q0; num_desc = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (ram_en !== 1'b1) begin errors++; $display("FAIL mid_in_issue got=%0b want=1", ram_en); end
    rstb = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, ram_en, ram_regce, match_valid, ram_addr, best_idx, best_dist, second_dist, match_ok} !== '0) begin
      errors++; $display("FAIL mid_reset busy=%0b en=%0b addr=%0d best=%0d second=%0d want all 0",
                         busy, ram_en, ram_addr, best_dist, second_dist);
    end
    rstb = 1'b0;
    repeat (LAT + 4) @(negedge clk);
    run_sweep(q0, 5'd8, lat, to);
    checks++;
    if (to || {best_idx, best_dist, second_dist} !== {4'd5, 9'd1, 9'd2}) begin
      errors++; $display("FAIL mid_restart got=%0d/%0d/%0d want=5/1/2", best_idx, best_dist, second_dist);
    end
  endtask

  task automatic test_busy_start();
    int lat; int e0;
    e0 = en_cnt;
    @(negedge clk);
    query = q0; num_desc = 5'd8; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    query = ~q0; num_desc = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!match_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (!match_valid || {best_idx, best_dist, second_dist} !== {4'd5, 9'd1, 9'd2}) begin
      errors++; $display("FAIL busy_start got=%0d/%0d/%0d want=5/1/2", best_idx, best_dist, second_dist);
    end
    checks++;
    if (en_cnt - e0 !== 8) begin errors++; $display("FAIL busy_en_cnt got=%0d want=8", en_cnt - e0); end
  endtask

  // Valids with a distance-0 word while idle must not reach the comparator.
  task automatic test_stray_valid();
    int lat; bit to;
    @(negedge clk);
    stray_dout = q0; stray = 1'b1;
    repeat (3) @(negedge clk);
    stray = 1'b0;
    run_sweep(q0, 5'd4, lat, to);
    checks++;
    if (to || {best_idx, best_dist, second_dist} !== {4'd1, 9'd4, 9'd4}) begin
      errors++; $display("FAIL stray_valid got=%0d/%0d/%0d want=1/4/4", best_idx, best_dist, second_dist);
    end
  endtask

  initial begin
    load_mem();
    test_reset();
    test_full_sweep();
    test_partial_tie();
    test_zero();
    test_one();
    test_clamp();
    test_reset_mid();
    test_busy_start();
    test_stray_valid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hamming_best_match.md
HAMMING_BEST_MATCH -- requirements
Module: hamming_best_match

Interface
REQ-001 Parameter DEPTH, default 1000: descriptor entries in the attached URAM.
REQ-002 Parameter DWIDTH, default 256: descriptor width in bits; a multiple of 64.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 Parameter DW, default $clog2(DWIDTH+1): distance width.
REQ-005 clk  in  1  clock; reset rstb, synchronous, active-high.
REQ-006 rstb  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse that begins a sweep; ignored while busy.
REQ-008 query  in  DWIDTH  query descriptor, sampled on an accepted start.
REQ-009 num_desc  in  AW+1  number of stored descriptors to compare, sampled on start.
REQ-010 ram_en, ram_regce  out  1  drive URAM mem_en and regceb.
REQ-011 ram_addr  out  AW  drives URAM read address addrb.
REQ-012 ram_valid  in  1  URAM o_valid.
REQ-013 ram_dout  in  DWIDTH  URAM doutb.
REQ-014 busy  out  1  sweep in progress.
REQ-015 match_valid  out  1  one-cycle result strobe.
REQ-016 best_idx  out  AW  index of the minimum distance.
REQ-017 best_dist, second_dist  out  DW  smallest and second-smallest distances.
REQ-018 match_ok  out  1  ratio-test pass (see Configuration).

Function
REQ-019 The FSM SHALL have states IDLE, ISSUE, DRAIN and DONE.
REQ-020 IDLE->ISSUE on start; the sweep latches query, sets n = min(num_desc, DEPTH) and sets busy=1.
REQ-021 ISSUE SHALL assert ram_en=ram_regce=1 with ram_addr = 0..n-1, one address per cycle, then go to DRAIN.
REQ-022 Outside ISSUE, ram_en=ram_regce=0 and ram_addr holds its last value.
REQ-023 Returned words SHALL be indexed by a return counter incremented on each ram_valid; the block is independent of URAM pipeline depth.
REQ-024 Each returned word SHALL pass a 3-stage pipeline: register(query XOR dout); per-64-bit popcounts; sum and compare.
REQ-025 Compare rule: d < best gives second=best, best=d, best_idx=idx; otherwise d < second gives second=d.
REQ-026 Ties SHALL keep the lower index.
REQ-027 best and second SHALL initialise to DWIDTH at sweep start.
REQ-028 DRAIN->DONE when the return count equals n and the compare pipeline is empty.
REQ-029 DONE SHALL pulse match_valid for one cycle, hold the results until the next start, clear busy, then go to IDLE.
REQ-030 n=0 SHALL go directly to DONE: best_dist=second_dist=DWIDTH, best_idx=0, match_ok=0.
REQ-031 n=1 SHALL give second_dist=DWIDTH.
REQ-032 ram_valid outside ISSUE/DRAIN SHALL be ignored.

Reset
REQ-033 rstb SHALL abort any sweep and force IDLE.
REQ-034 On reset, every output SHALL be 0, including best_dist and second_dist.
REQ-035 On reset, the counters and the pipeline valid bits SHALL be cleared.

Configuration
REQ-036 Macro HBM_RATIO_TEST_EN defined: match_ok = (4*best_dist < 3*second_dist), computed at width DW+2.
REQ-037 Macro HBM_RATIO_TEST_EN undefined: match_ok = (n != 0), and the multipliers are absent.

Structure
REQ-038 Package hbm_pkg SHALL hold the FSM state enum and the constants POP_CHUNK=64, RATIO_NUM=3 and RATIO_DEN=4.
REQ-039 A single sub-module, hbm_popcount (DWIDTH in, DW out, 2-cycle registered), SHALL implement stages 2-3 of the pipeline.

Verification
REQ-040 Model the URAM with DEPTH=8 and 6-cycle latency. Load words 0..7 with popcount(q XOR w) = 9,4,7,4,200,1,3,2 and set num_desc=8: match_valid fires with best_idx=5, best_dist=1, second_dist=2, match_ok=1 (ratio on).
REQ-041 Same memory image with num_desc=4: best_idx=1 (tie with 3 keeps the lower index), best_dist=4, second_dist=4, match_ok=0.
REQ-042 num_desc=0: no ram_en pulses; match_valid fires 2 cycles after start with best_dist=DWIDTH and match_ok=0.
REQ-043 num_desc=20 with DEPTH=8: exactly 8 ram_en cycles, addresses 0..7.
REQ-044 rstb asserted mid-ISSUE: next cycle busy=0, ram_en=0, all outputs 0; a new start then completes correctly.
REQ-045 Second start while busy: ignored, and the result matches the first query.
